// File: rtl/vjtag_regbank_if.sv
// Bundle between the virtual-JTAG shift/update stage and the regbank, plus the counter pins.
// Latency: none (wires only).
// Backpressure: none; strobes are fire-and-forget, with spacing guaranteed by the JTAG stage.
interface vjtag_regbank_if;
  logic [7:0]  jtag_addr;
  logic [7:0]  jtag_data;
  logic        jtag_we;
  logic        jtag_addr_we;
  logic [7:0]  jtag_rdata;
  logic        event_in;
  logic        cnt_en;
  logic        overflow;
  logic [31:0] count;

  // JTAG stage / event source side
  modport master (
    output jtag_addr, jtag_data, jtag_we, jtag_addr_we, event_in,
    input  jtag_rdata, cnt_en, overflow, count
  );

  // Register bank side
  modport slave (
    input  jtag_addr, jtag_data, jtag_we, jtag_addr_we, event_in,
    output jtag_rdata, cnt_en, overflow, count
  );
endinterface

// File: rtl/vjtag_regbank.sv
// Purpose: clk-domain register bank fed by tck-domain JTAG strobes; drives an event counter with snapshot.
// Latency: a write lands 3 clk edges after the strobe is first sampled; jtag_rdata follows 1 edge later.
// Backpressure: none; one write per strobe rising edge. Optional VJTAG_REGBANK_SCRATCH_EN adds scratch at 0x20-0x23.
module vjtag_regbank #(
  parameter logic [7:0] ID = 8'hC3
) (
  input  logic           clk,
  input  logic           rst_n,
  vjtag_regbank_if.slave bus
);

  localparam logic [7:0] A_ID     = 8'h00;
  localparam logic [7:0] A_CTRL   = 8'h01;
  localparam logic [7:0] A_STATUS = 8'h02;

  // Synchroniser and edge-detect flops for the two tck strobes
  logic r_we_s1, r_we_s2, r_we_d;
  logic r_aw_s1, r_aw_s2, r_aw_d;
  logic w_wr_p, w_aw_p;

  logic [7:0]  r_addr;
  logic [7:0]  w_wr_addr;
  logic [7:0]  w_wdata;
  logic        r_en;
  logic        r_ov;
  logic [31:0] r_count;
  logic [31:0] r_snap;
  logic        r_evt_d;
  logic [7:0]  r_rdata;
  logic [7:0]  w_rdata;

  logic        w_ctrl_wr, w_stat_wr;
  logic        w_soft, w_clr, w_snap, w_w1c, w_inc, w_wrap;
  logic [31:0] w_count_nxt;

`ifdef VJTAG_REGBANK_SCRATCH_EN
  logic [3:0][7:0] r_scratch;
  logic            w_scr_wr;
`endif

  // Bits of the write data not decoded in every build
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, w_wdata[7:4]};

  // Two-flop synchronisers followed by one history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_s1 <= 1'b0;
      r_we_s2 <= 1'b0;
      r_we_d  <= 1'b0;
      r_aw_s1 <= 1'b0;
      r_aw_s2 <= 1'b0;
      r_aw_d  <= 1'b0;
    end else begin
      r_we_s1 <= bus.jtag_we;
      r_we_s2 <= r_we_s1;
      r_we_d  <= r_we_s2;
      r_aw_s1 <= bus.jtag_addr_we;
      r_aw_s2 <= r_aw_s1;
      r_aw_d  <= r_aw_s2;
    end
  end

  assign w_wr_p  = r_we_s2 & ~r_we_d;
  assign w_aw_p  = r_aw_s2 & ~r_aw_d;
  assign w_wdata = bus.jtag_data;
  // A simultaneous address strobe redirects the write to the new address
  assign w_wr_addr = w_aw_p ? bus.jtag_addr : r_addr;

  // Write decode and next-count arithmetic with SOFT_RST > CLR > increment
  always_comb begin
    w_ctrl_wr   = w_wr_p && (w_wr_addr == A_CTRL);
    w_stat_wr   = w_wr_p && (w_wr_addr == A_STATUS);
    w_soft      = w_ctrl_wr && w_wdata[0];
    w_clr       = w_ctrl_wr && w_wdata[2];
    w_snap      = w_ctrl_wr && w_wdata[3];
    w_w1c       = w_stat_wr && w_wdata[0];
    w_inc       = bus.event_in && !r_evt_d && r_en;
    w_wrap      = w_inc && (r_count == 32'hFFFF_FFFF) && !w_clr && !w_soft;
    w_count_nxt = r_count;
    if (w_soft || w_clr) begin
      w_count_nxt = 32'd0;
    end else if (w_inc) begin
      w_count_nxt = r_count + 32'd1;
    end
  end

`ifdef VJTAG_REGBANK_SCRATCH_EN
  assign w_scr_wr = w_wr_p && (w_wr_addr[7:2] == 6'b001000);
`endif

  // Address latch, control/status state, counter and snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 8'h00;
      r_en    <= 1'b0;
      r_ov    <= 1'b0;
      r_count <= 32'd0;
      r_snap  <= 32'd0;
      r_evt_d <= 1'b0;
`ifdef VJTAG_REGBANK_SCRATCH_EN
      r_scratch <= '0;
`endif
    end else begin
      r_evt_d <= bus.event_in;
      r_count <= w_count_nxt;
      if (w_aw_p) begin
        r_addr <= bus.jtag_addr;
      end
      if (w_soft) begin
        r_en   <= 1'b0;
        r_ov   <= 1'b0;
        r_snap <= 32'd0;
      end else begin
        if (w_ctrl_wr) begin
          r_en <= w_wdata[1];
        end
        // Snapshot takes the value before any same-cycle increment
        if (w_snap) begin
          r_snap <= r_count;
        end
        // A wrap in the same cycle wins over the W1C clear
        if (w_wrap) begin
          r_ov <= 1'b1;
        end else if (w_w1c) begin
          r_ov <= 1'b0;
        end
      end
`ifdef VJTAG_REGBANK_SCRATCH_EN
      if (w_soft) begin
        r_scratch <= '0;
      end else if (w_scr_wr) begin
        r_scratch[w_wr_addr[1:0]] <= w_wdata;
      end
`endif
    end
  end

  // Read mux over the latched address
  always_comb begin
    w_rdata = 8'h00;
    case (r_addr)
      A_ID:     w_rdata = ID;
      A_CTRL:   w_rdata = {6'b0, r_en, 1'b0};
      A_STATUS: w_rdata = {6'b0, r_en, r_ov};
      8'h10:    w_rdata = r_snap[7:0];
      8'h11:    w_rdata = r_snap[15:8];
      8'h12:    w_rdata = r_snap[23:16];
      8'h13:    w_rdata = r_snap[31:24];
`ifdef VJTAG_REGBANK_SCRATCH_EN
      8'h20:    w_rdata = r_scratch[0];
      8'h21:    w_rdata = r_scratch[1];
      8'h22:    w_rdata = r_scratch[2];
      8'h23:    w_rdata = r_scratch[3];
`endif
      default:  w_rdata = 8'h00;
    endcase
  end

  // Registered read data for the JTAG capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 8'h00;
    end else begin
      r_rdata <= w_rdata;
    end
  end

  assign bus.jtag_rdata = r_rdata;
  assign bus.cnt_en     = r_en;
  assign bus.overflow   = r_ov;
  assign bus.count      = r_count;

endmodule
